// File: rtl/pipe_adder_pkg.sv
// Shared types and the result/overflow datapath function for pipe_adder_acc.
// PIPE_ADDER_SAT_EN selects saturating ACC/SUB instead of wrapping.
package pipe_adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_ACC = 2'b01,
        MODE_CLR = 2'b10,
        MODE_SUB = 2'b11
    } mode_e;

    // Widest operand the shared function handles; callers must keep WIDTH < MAX_W.
    localparam int MAX_W = 32;

    typedef struct packed {
        logic [MAX_W:0] y;
        logic           ovf;
        logic [MAX_W:0] acc;
    } result_t;

    // Operands arrive zero-extended to MAX_W; 'width' is the real operand width,
    // so y/acc are masked to width+1 bits and the ACC carry is bit width+1.
    function automatic result_t compute_result(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [MAX_W:0]   acc,
        input mode_e            mode,
        input int unsigned      width
    );
        result_t          r;
        logic [MAX_W:0]   mask;
        logic [MAX_W+1:0] sum;
        logic [MAX_W:0]   diff;
        logic             carry;

        mask  = {(MAX_W+1){1'b1}} >> (MAX_W - width);
        sum   = {1'b0, acc} + {2'b00, a} + {2'b00, b};
        carry = (sum >> (width + 1)) != '0;
        diff  = {1'b0, a} - {1'b0, b};

        r.y   = '0;
        r.ovf = 1'b0;
        r.acc = acc;
        case (mode)
            MODE_ADD: r.y = {1'b0, a} + {1'b0, b};
            MODE_SUB: begin
                r.ovf = (a < b);
`ifdef PIPE_ADDER_SAT_EN
                r.y = r.ovf ? '0 : (diff & mask);
`else
                r.y = diff & mask;
`endif
            end
            MODE_ACC: begin
                r.ovf = carry;
`ifdef PIPE_ADDER_SAT_EN
                r.y = carry ? mask : (sum[MAX_W:0] & mask);
`else
                r.y = sum[MAX_W:0] & mask;
`endif
                r.acc = r.y;
            end
            MODE_CLR: r.acc = '0;
            default: r.acc = acc;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_adder_acc_if.sv
// Operand and result streams of pipe_adder_acc; slave = design side, master = driver side.
interface pipe_adder_acc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   y;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, y, ovf
    );

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, y, ovf
    );
endinterface

// File: rtl/pipe_stage.sv
// Generic valid/ready register slice; accepts whenever empty or its output is being taken.
module pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              adv;

    always_comb begin
        adv     = !valid_q || out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (adv) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q;
    assign out_data  = data_q;
endmodule

// File: rtl/pipe_adder_acc.sv
// Two-stage add/sub/accumulate pipeline with backpressure and a result-beat counter.
// Build option: PIPE_ADDER_SAT_EN (saturating ACC/SUB, handled in pipe_adder_pkg).
module pipe_adder_acc
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    pipe_adder_acc_if.slave        bus,
    output logic [CNT_W-1:0]       txn_count
);
    localparam int S1_W = 2 * WIDTH + 2;
    localparam int S2_W = WIDTH + 2;

    logic [S1_W-1:0]  s1_in;
    logic [S1_W-1:0]  s1_data;
    logic             s1_valid;
    logic             s2_in_ready;
    logic [S2_W-1:0]  s2_in;
    logic [S2_W-1:0]  s2_data;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_mode;
    result_t          res;
    logic             beat_moves;
    logic             res_unused;

    logic [WIDTH:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign s1_in = {bus.a, bus.b, bus.mode};

    pipe_stage #(.DATA_W(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    assign {s1_a, s1_b, s1_mode} = s1_data;

    always_comb begin
        res = compute_result(MAX_W'(s1_a), MAX_W'(s1_b), (MAX_W+1)'(acc_q),
                             mode_e'(s1_mode), WIDTH);
    end

    assign s2_in      = {res.y[WIDTH:0], res.ovf};
    assign res_unused = ^{res.y[MAX_W:WIDTH+1], res.acc[MAX_W:WIDTH+1]};

    pipe_stage #(.DATA_W(S2_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_data)
    );

    assign {bus.y, bus.ovf} = s2_data;

    // acc moves only on the S1->S2 transfer, so a stalled beat never accumulates twice.
    always_comb begin
        beat_moves = s1_valid && s2_in_ready;
        acc_d      = beat_moves ? res.acc[WIDTH:0] : acc_q;
        cnt_d      = cnt_q + CNT_W'(bus.out_valid && bus.out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign txn_count = cnt_q;
endmodule

// File: tb/tb_pipe_adder_acc.sv
// Scoreboard bench for pipe_adder_acc (WIDTH=8); a second instance with CNT_W=4 covers counter wrap.
module tb_pipe_adder_acc;
    import pipe_adder_pkg::*;

    typedef struct {
        logic [8:0] y;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] txn_count;
    logic [3:0]  txn_count4;

    always #5 clk = ~clk;

    pipe_adder_acc_if #(.WIDTH(8)) bus ();
    pipe_adder_acc_if #(.WIDTH(8)) bus4 ();

    pipe_adder_acc #(.WIDTH(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .txn_count (txn_count)
    );

    pipe_adder_acc #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus4),
        .txn_count (txn_count4)
    );

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.a         = bus.a;
    assign bus4.b         = bus.b;
    assign bus4.mode      = bus.mode;
    assign bus4.out_ready = bus.out_ready;

    int   total = 0;
    int   bad = 0;
    int   edge_n = 0;
    int   m_acc = 0;
    int   exp_cnt = 0;
    int   stall_acc = 0;
    int   n_txn = 0;
    bit   lat_en = 0;
    bit   prev_stall = 0;
    bit   rnd_done = 0;
    logic [8:0] held_y;
    logic       held_ovf;
    exp_t sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: inputs only change just after a rising edge, so the values seen here
    // are the ones the next rising edge will act on.
    always @(negedge clk) begin
        exp_t e;
        int   s;
        if (rst) begin
            sb_q.delete();
            m_acc      = 0;
            exp_cnt    = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check_val("hold_valid", 32'(bus.out_valid), 32'd1);
                check_val("hold_y", 32'(bus.y), 32'(held_y));
                check_val("hold_ovf", 32'(bus.ovf), 32'(held_ovf));
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held_y     = bus.y;
            held_ovf   = bus.ovf;

            if (bus.out_valid && bus.out_ready) begin
                check_val("txn_count", 32'(txn_count), 32'(exp_cnt));
                check_val("txn_count4", 32'(txn_count4), 32'(exp_cnt % 16));
                if (sb_q.size() == 0) begin
                    check_val("spurious_beat", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("y", 32'(bus.y), 32'(e.y));
                    check_val("ovf", 32'(bus.ovf), 32'(e.ovf));
                    if (lat_en) check_val("latency", 32'(edge_n - e.cyc), 32'd2);
                    $display("txn %0d: y=%03h ovf=%0b (want y=%03h ovf=%0b)",
                             n_txn, bus.y, bus.ovf, e.y, e.ovf);
                end
                n_txn++;
                exp_cnt++;
            end

            if (bus.in_valid && bus.in_ready) begin
                e.y   = '0;
                e.ovf = 1'b0;
                e.cyc = edge_n;
                case (bus.mode)
                    MODE_ADD: e.y = 9'(int'(bus.a) + int'(bus.b));
                    MODE_SUB: begin
                        e.ovf = bus.a < bus.b;
`ifdef PIPE_ADDER_SAT_EN
                        e.y = e.ovf ? 9'd0 : 9'(int'(bus.a) - int'(bus.b));
`else
                        e.y = 9'(int'(bus.a) - int'(bus.b));
`endif
                    end
                    MODE_ACC: begin
                        s     = m_acc + int'(bus.a) + int'(bus.b);
                        e.ovf = s > 511;
`ifdef PIPE_ADDER_SAT_EN
                        e.y = e.ovf ? 9'h1FF : 9'(s);
`else
                        e.y = 9'(s);
`endif
                        m_acc = int'(e.y);
                    end
                    default: m_acc = 0;
                endcase
                sb_q.push_back(e);
                if (!bus.out_ready) stall_acc++;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send(input logic [1:0] m, input logic [7:0] x, input logic [7:0] z);
        int   n = 0;
        logic ok;
        bus.in_valid = 1'b1;
        bus.a        = x;
        bus.b        = z;
        bus.mode     = m;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check_val("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.mode     = MODE_CLR;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while ((sb_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = MODE_ADD;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_y", 32'(bus.y), 32'd0);
        check_val("rst_ovf", 32'(bus.ovf), 32'd0);
        check_val("rst_txn_count", 32'(txn_count), 32'd0);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_acc", 32'(dut.acc_q), 32'd0);
        @(posedge clk);
        #1;

        // ADD stream, full throughput, latency checked per beat
        lat_en = 1;
        t0 = edge_n;
        for (int i = 0; i < 25; i++) send(MODE_ADD, 8'(i), 8'(i));
        check_val("throughput", 32'(edge_n - t0), 32'd25);
        drain();
        lat_en = 0;
        check_val("count_25", 32'(txn_count), 32'd25);

        // ADD/SUB boundaries
        send(MODE_ADD, 8'hFF, 8'hFF);
        send(MODE_SUB, 8'd3, 8'd5);
        send(MODE_SUB, 8'd5, 8'd3);
        send(MODE_SUB, 8'd7, 8'd7);
        send(MODE_SUB, 8'h00, 8'hFF);
        drain();

        // CLR then ACC 0x80+0x80 four times
        send(MODE_CLR, 8'h55, 8'hAA);
        for (int i = 0; i < 4; i++) send(MODE_ACC, 8'h80, 8'h80);
        drain();
        check_val("acc_after_acc4", 32'(dut.acc_q), 32'(m_acc));

        // Backpressure: out_ready low for 5 cycles while streaming ACC beats
        send(MODE_CLR, 8'h00, 8'h00);
        drain();
        stall_acc     = 0;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(MODE_ACC, 8'($urandom), 8'($urandom));
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check_val("stall_accepts", 32'(stall_acc), 32'd2);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check_val("acc_after_stall", 32'(dut.acc_q), 32'(m_acc));

        // Random modes with random backpressure
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    if (!rnd_done) bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check_val("acc_after_random", 32'(dut.acc_q), 32'(m_acc));

        // Reset with both stages full of ACC beats
        bus.out_ready = 1'b0;
        send(MODE_ACC, 8'd10, 8'd20);
        send(MODE_ACC, 8'd30, 8'd40);
        @(negedge clk);
        check_val("full_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        pulse_reset();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("midrst_acc", 32'(dut.acc_q), 32'd0);
        check_val("midrst_txn_count", 32'(txn_count), 32'd0);
        @(posedge clk);
        #1;
        send(MODE_ACC, 8'd1, 8'd2);
        drain();
        check_val("acc_1_2", 32'(dut.acc_q), 32'd3);

        // Counter wrap on the CNT_W=4 instance
        pulse_reset();
        for (int i = 0; i < 17; i++) send(MODE_ADD, 8'($urandom), 8'($urandom));
        drain();
        @(negedge clk);
        check_val("wrap_cnt4", 32'(txn_count4), 32'd1);
        check_val("wrap_cnt16", 32'(txn_count), 32'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d want=finish", edge_n);
        $fatal(1, "timeout");
    end
endmodule
